// File: rtl/vdc_pixelshift.sv
// vdc_pixelshift: turns the per-column char bitmap byte plus its attribute
// byte into a 4-bit RGBI pixel stream, one pixel per dot enable. Handles
// reverse, underline, blink, semigraphics gap fill and default fg/bg colours.
// A column loaded on its newCol dot shows its first pixel on the next dot.
module vdc_pixelshift #(
  parameter int C_LATCH_WIDTH = 8,
  parameter int S_LATCH_WIDTH = 128
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot,
  input  logic       newCol,
  input  logic       newFrame,
  input  logic [7:0] col,
  input  logic [4:0] line,
  input  logic       rowbuf,
  input  logic [7:0] attrbuf [2][S_LATCH_WIDTH],
  input  logic [7:0] charbuf [C_LATCH_WIDTH],
  input  logic [7:0] reg_hd,
  input  logic [3:0] reg_cth,
  input  logic [4:0] reg_ul,
  input  logic [3:0] reg_fg,
  input  logic [3:0] reg_bg,
  input  logic       reg_atr,
  input  logic       reg_rvs,
  input  logic       reg_semi,
  input  logic       reg_crate,
  output logic [3:0] pixel,
  output logic       de
);

  localparam int RI_W = (C_LATCH_WIDTH > 1) ? $clog2(C_LATCH_WIDTH) : 1;
  localparam int AI_W = (S_LATCH_WIDTH > 1) ? $clog2(S_LATCH_WIDTH) : 1;

  // Column state: charbuf read pointer, pixel index, latched byte/attribute.
  logic [RI_W-1:0] ri_q, ri_d;
  logic [3:0]      px_q, px_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      attr_q, attr_d;
  logic            valid_q, valid_d;
  // Frame counter driving the blink phase.
  logic [4:0]      blink_q, blink_d;
  // Registered outputs.
  logic [3:0]      pixel_q, pixel_d;
  logic            de_q, de_d;

  // Per-pixel decode of the current state.
  logic [7:0]      attr_eff;
  logic            src_bit;
  logic            ul_bit;
  logic            blank_bit;
  logic            out_bit;
  logic            blink_off;
  logic [3:0]      colour;
  logic [7:0]      col_m1;
  logic [AI_W-1:0] col_idx;
  logic            attr_in_range;
  logic            col_shown;

  assign col_m1        = col - 8'd1;
  assign col_idx       = AI_W'(col_m1);
  assign attr_in_range = ({24'd0, col_m1} < 32'(S_LATCH_WIDTH));
  assign col_shown     = (col != 8'd0) && (col <= reg_hd);

  // Pixel colour for the current px: source bit, then underline, blink, reverse.
  // The attribute byte is latched at load; with attributes disabled the live
  // fg register is used so fg changes show up immediately, even mid-char.
  always_comb begin
    attr_eff  = reg_atr ? attr_q : {4'h0, reg_fg};
    if (px_q[3] == 1'b0) begin
      src_bit = shift_q[3'd7 - px_q[2:0]];
    end else begin
      src_bit = reg_semi & shift_q[0];
    end
    ul_bit    = (attr_eff[5] && (line == reg_ul)) ? 1'b1 : src_bit;
    blink_off = reg_crate ? blink_q[4] : blink_q[3];
    blank_bit = (blink_off && attr_eff[4]) ? 1'b0 : ul_bit;
    out_bit   = blank_bit ^ attr_eff[6] ^ reg_rvs;
    colour    = (valid_q && out_bit) ? attr_eff[3:0] : reg_bg;
  end

  // Next-state: blink counter on newFrame, column load/advance on dot.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    ri_d    = ri_q;
    px_d    = px_q;
    shift_d = shift_q;
    attr_d  = attr_q;
    valid_d = valid_q;
    blink_d = blink_q;
    pixel_d = pixel_q;
    de_d    = de_q;

    if (newFrame) begin
      blink_d = blink_q + 5'd1;
    end

    if (dot) begin
      pixel_d = colour;
      de_d    = valid_q;
      if (newCol) begin
        px_d = 4'd0;
        if (col == 8'd0) begin
          ri_d    = '0;
          valid_d = 1'b0;
        end else if (col_shown) begin
          shift_d = charbuf[ri_q];
          attr_d  = attr_in_range ? attrbuf[rowbuf][col_idx] : 8'h00;
          ri_d    = (ri_q == RI_W'(C_LATCH_WIDTH - 1)) ? '0 : ri_q + RI_W'(1);
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else if (px_q < reg_cth) begin
        // Index saturates at reg_cth so extra dots repeat the last pixel.
        px_d = px_q + 4'd1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      ri_q    <= '0;
      px_q    <= 4'd0;
      shift_q <= 8'h00;
      attr_q  <= 8'h00;
      valid_q <= 1'b0;
      blink_q <= 5'd0;
      pixel_q <= 4'h0;
      de_q    <= 1'b0;
    end else begin
      ri_q    <= ri_d;
      px_q    <= px_d;
      shift_q <= shift_d;
      attr_q  <= attr_d;
      valid_q <= valid_d;
      blink_q <= blink_d;
      pixel_q <= pixel_d;
      de_q    <= de_d;
    end
  end

  assign pixel = pixel_q;
  assign de    = de_q;

endmodule
